// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory responder slice.
//   - state_e          : responder FSM states (IDLE, WAIT, RESP)
//   - MEM_WAIT_DEFAULT : default wait states per access
//   - WAIT_CNT_W       : wait counter width (covers 0..15)
//   - WORD_IDX_LSB     : byte-offset bits dropped from a byte address
//   - word_idx_msb()   : top bit of the word index for a given ADDR_W
package mem_pkg;

  localparam int MEM_WAIT_DEFAULT = 2;
  localparam int WAIT_CNT_W       = 4;
  localparam int WORD_IDX_LSB     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Word index of a byte address is addr[word_idx_msb(ADDR_W):WORD_IDX_LSB].
  function automatic int word_idx_msb(input int addr_w);
    return addr_w + WORD_IDX_LSB - 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: 2^ADDR_W x DATA_W storage for the unified instruction/data memory.
// Ports:
//   clkvar, rst          : clock, async active-high reset (output registers only)
//   wr_en/wr_addr/wr_data: synchronous write port
//   rd_en/rd_addr/rd_data: synchronous read port, rd_data holds between reads
//   dbg_addr/dbg_rdata   : free-running second read port (MEM_DEBUG_PORT_EN only)
// Macro: MEM_DEBUG_PORT_EN enables the debug read port.
// Reads at the same edge as a write to the same word return the old value.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clkvar,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents start at zero in simulation (power-up image).
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] rd_data_q;

  // NOTE: the storage array has no reset; only the output registers do.
  always_ff @(posedge clkvar) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clkvar or posedge rst) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

`ifdef MEM_DEBUG_PORT_EN
  logic [DATA_W-1:0] dbg_rdata_q;

  always_ff @(posedge clkvar or posedge rst) begin
    if (rst) dbg_rdata_q <= '0;
    else     dbg_rdata_q <= mem_q[dbg_addr];
  end

  assign dbg_rdata = dbg_rdata_q;
`else
  // Single read port build: no debug path into the array.
`endif

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle CPU. Serves word
// read/write requests with WAIT wait states and a one-cycle ready pulse.
// Ports:
//   clkvar, rst     : clock, async active-high reset
//   req, we         : request and write flag, sampled in IDLE only
//   addr            : byte address, word index addr[ADDR_W+1:2]
//   wdata           : write data, sampled with req
//   rdata           : registered read data, holds until the next read completes
//   ready           : one-cycle completion pulse (RESP state)
//   busy            : high from the cycle after acceptance through ready
//   dbg_addr/_rdata : registered debug read port (MEM_DEBUG_PORT_EN only)
// Macro: MEM_DEBUG_PORT_EN adds the debug port; CPU side is unchanged.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int WAIT   = MEM_WAIT_DEFAULT
) (
  input  logic              clkvar,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
`endif
);

  localparam int                    IDX_MSB  = word_idx_msb(ADDR_W);
  localparam logic [WAIT_CNT_W-1:0] WAIT_CNT = WAIT_CNT_W'(WAIT);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;

  logic [ADDR_W-1:0]       req_idx;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_idx;
  logic                    wr_en;

  // Byte offset and address bits above the array wrap are ignored.
  assign req_idx = addr[IDX_MSB:WORD_IDX_LSB];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IDX_MSB+1], addr[WORD_IDX_LSB-1:0]};

  // NOTE: defaults first so every path assigns every signal; no latches inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = req_idx;
          wdata_d = wdata;
          cnt_d   = WAIT_CNT;
          busy_d  = 1'b1;
          if (WAIT_CNT == '0) begin
            // Zero wait states: the array is read straight from the request.
            state_d = ST_RESP;
            ready_d = 1'b1;
            rd_en   = ~we;
            rd_idx  = req_idx;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          rd_en   = ~we_q;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Write commits at the edge leaving RESP; reset forces IDLE first, so an
  // in-flight write never reaches the array.
  assign wr_en = (state_q == ST_RESP) && we_q;

  // NOTE: clocked state uses non-blocking '<='; combinational logic uses '='.
  always_ff @(posedge clkvar or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clkvar    (clkvar),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (idx_q),
    .wr_data   (wdata_q),
    .rd_en     (rd_en),
    .rd_addr   (rd_idx),
    .rd_data   (rdata)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
`endif
  );

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU. It serves the control FSM's word read and write requests from a unified instruction/data array, adding a configurable number of wait states. It signals completion with a one-cycle `ready` pulse, so the control FSM can hold its memory state until the access finishes. It sits between the datapath's memory address/data mux (IorD, MemWrite) and the storage array.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width. Array depth is 2^ADDR_W words.
- `DATA_W`, default 32: data word width.
- `WAIT`, default 2: wait states per access, range 0..15.

Ports:
- `clkvar` input 1: clock. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input 1: access request from the control FSM. Sampled only in IDLE.
- `we` input 1: 1 = write (MemWrite), 0 = read. Sampled with `req`.
- `addr` input 32: byte address. Word index is `addr[ADDR_W+1:2]`.
- `wdata` input DATA_W: write data. Sampled with `req`.
- `rdata` output DATA_W: read data. Registered.
- `ready` output 1: one-cycle completion pulse.
- `busy` output 1: high from the cycle after `req` is accepted until the cycle `ready` is high, inclusive.
- `dbg_addr` input ADDR_W: debug read word index. Present only with MEM_DEBUG_PORT_EN.
- `dbg_rdata` output DATA_W: debug read data. Present only with MEM_DEBUG_PORT_EN.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - On `req`=1, latch `we`, `addr[ADDR_W+1:2]` and `wdata`, and load the wait counter with WAIT.
  - If WAIT=0, go to RESP. Otherwise go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 1, go to RESP.
- RESP:
  - `ready`=1 for this one cycle.
  - Read: `rdata` is loaded from the array at the edge entering RESP and holds until the next read completes.
  - Write: the array word is written at the edge leaving RESP. `rdata` is unchanged.
  - Always return to IDLE.
- `req` outside IDLE is ignored, not queued. The requester must drop or re-assert `req` after `ready`.
- Address wrap: `addr[1:0]` and the bits above `ADDR_W+1` are ignored. Byte addresses 0x000 and 0x400 (ADDR_W=8) hit the same word.
- Writes are whole-word; there are no byte enables.
- Reset:
  - State goes to IDLE, counter to 0, `rdata`=0, `ready`=0, `busy`=0, `dbg_rdata`=0.
  - An in-flight write is dropped with no array update.
  - Array contents are not cleared by `rst`. They are zero-initialized at simulation start.

## Timing
- `req` is sampled at edge E0 in IDLE. `ready` is high in the cycle following edge E0+WAIT, a latency of WAIT+1 cycles.
- Minimum request spacing is WAIT+2 cycles: the next `req` is sampled at the first edge after RESP.
- `busy` and `ready` are registered outputs with no combinational path from `req`.
- Write visibility: a read accepted in the IDLE cycle right after a write's RESP returns the new data.
- Debug read and CPU write to the same word at the same edge: `dbg_rdata` returns the old value, then the new value one cycle later.

## Configuration
- `MEM_DEBUG_PORT_EN` defined:
  - `dbg_addr`/`dbg_rdata` exist.
  - `dbg_rdata` is registered: it shows the array word at `dbg_addr` one cycle after `dbg_addr` is presented.
  - The port is independent of the CPU FSM and never stalls it.
- `MEM_DEBUG_PORT_EN` undefined: ports absent, no second read port.
- CPU-side behaviour is identical in both builds.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - `MEM_WAIT_DEFAULT`=2;
  - word-index helper width constants.
- Sub-module `mem_array`:
  - 2^ADDR_W x DATA_W;
  - one synchronous write port and one synchronous read port;
  - second synchronous read port only under `MEM_DEBUG_PORT_EN`.
- The FSM, counter and latches live in `mem_responder`.

## Test plan
- Reset: assert `rst` mid-WAIT of a write of 0xDEADBEEF to 0x10. Expect `ready`, `busy` and `rdata` = 0 immediately, and a later read of 0x10 returns 0.
- Write then read, WAIT=2:
  - Write 0x12345678 to 0x24 with `req` at E0. Expect `ready` only in the cycle after E2 and `busy` high for cycles 1..3.
  - Read 0x24 next IDLE cycle. Expect `rdata`=0x12345678 with `ready`.
- WAIT=0, back-to-back reads of 0x00 and 0x04 (preloaded 0xA, 0xB):
  - Expect `ready` in the cycle after each sampling edge.
  - Expect `rdata` 0xA, then 0xB.
  - Expect `req` held high during RESP to be ignored.
- Wrap and alignment, ADDR_W=8: write 0x55 to 0x403, then read 0x000. Expect 0x55.
- Ignored request: pulse `req` (write, 0x08, 0x77) during WAIT of a read of 0x0C. Expect 0x08 unchanged and only one `ready` pulse.
- With `MEM_DEBUG_PORT_EN`: hold `dbg_addr`=0x09 while the CPU writes 0x99 to byte 0x24. Expect `dbg_rdata` old value at the write edge, then 0x99 one cycle later, with CPU `ready` timing unchanged.
